// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store front-end that aligns core requests into RAM word accesses with emulated latency.
// Define LSU_MISALIGN_EXC_EN to report misaligned/illegal requests as errors instead of forcing alignment.
module lsu_mem_ctrl #(
    parameter int LAT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    output logic [31:0] mem_raddr,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        wen_q, uns_q, err_q, mis_e, act;
    logic [31:0] addr_q, wdata_q, rdata_q, a_eff, sh, ext;
    logic [1:0]  size_q, s_eff;
    logic [4:0]  bsh;
    logic [3:0]  mask;

`ifdef LSU_MISALIGN_EXC_EN
    always_comb begin
        s_eff = req_size;
        a_eff = req_addr;
        mis_e = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    end
`else
    // Illegal size degrades to a word access; addresses snap to natural alignment.
    always_comb begin
        s_eff = (req_size == 2'd3) ? 2'd2 : req_size;
        a_eff = {req_addr[31:2], (s_eff == 2'd2) ? 2'b00 :
                                 (s_eff == 2'd1) ? {req_addr[1], 1'b0} : req_addr[1:0]};
        mis_e = 1'b0;
    end
`endif

    always_comb begin
        bsh  = {addr_q[1:0], 3'b000};
        sh   = mem_rdata >> bsh;
        ext  = (size_q == 2'd0) ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
               (size_q == 2'd1) ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;
        mask = (size_q == 2'd0) ? 4'b0001 << addr_q[1:0] :
               (size_q == 2'd1) ? 4'b0011 << addr_q[1:0] : 4'b1111;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (req_valid) begin
                cnt_n = 4'(LAT_CYCLES - 1);
                if (mis_e) state_n = RESP;
                else if (LAT_CYCLES > 0) state_n = WAIT;
                else state_n = ACCESS;
            end
            WAIT: begin
                if (cnt == 4'd0) state_n = ACCESS;
                else cnt_n = cnt - 4'd1;
            end
            ACCESS: state_n = RESP;
            RESP: if (resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && req_valid) begin
                wen_q   <= req_wen;
                uns_q   <= req_unsigned;
                err_q   <= mis_e;
                addr_q  <= a_eff;
                wdata_q <= req_wdata;
                size_q  <= s_eff;
                rdata_q <= 32'd0;
            end
            if (state == ACCESS) rdata_q <= wen_q ? 32'd0 : ext;
        end
    end

    // Outputs are gated by resetn so they read zero during reset, not just after the next edge.
    always_comb begin
        act        = resetn && state == ACCESS;
        req_ready  = resetn && state == IDLE;
        resp_valid = resetn && state == RESP;
        resp_rdata = resetn ? rdata_q : 32'd0;
        resp_err   = resetn & err_q;
        mem_valid  = act;
        mem_wen    = act & wen_q;
        mem_raddr  = act ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_waddr  = mem_raddr;
        mem_wdata  = act ? wdata_q << bsh : 32'd0;
        mem_wmask  = act ? {4'b0000, mask} : 8'd0;
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed checks of three lsu_mem_ctrl instances (LAT_CYCLES 0, 3, 2) against a small RAM model.
module tb_lsu_mem_ctrl;
    logic        clk = 0;
    logic        resetn = 0;
    logic [2:0]  rv = 3'b000;
    logic        req_wen = 0, req_unsigned = 0, resp_ready = 1;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [1:0]  req_size = 0;
    logic        rr [3];
    logic        vv [3];
    logic        er [3];
    logic        mv [3];
    logic        mw [3];
    logic [31:0] rd [3];
    logic [31:0] mra [3];
    logic [31:0] mwa [3];
    logic [31:0] mwd [3];
    logic [7:0]  mwm [3];
    logic [31:0] mrd [3];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        logic [31:0] ram [4];
        always @(posedge clk) begin
            if (!resetn) begin
                ram[0] <= 32'h8899AABB;
                ram[1] <= 32'd0;
                ram[2] <= 32'd0;
                ram[3] <= 32'd0;
            end else if (mv[g] && mw[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mwm[g][b]) ram[mwa[g][3:2]][8*b +: 8] <= mwd[g][8*b +: 8];
            end
        end
        assign mrd[g] = ram[mra[g][3:2]];
        lsu_mem_ctrl #(.LAT_CYCLES(g == 0 ? 0 : g == 1 ? 3 : 2)) dut (
            .clk(clk), .resetn(resetn),
            .req_valid(rv[g]), .req_ready(rr[g]), .req_wen(req_wen), .req_addr(req_addr),
            .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
            .resp_valid(vv[g]), .resp_ready(resp_ready), .resp_rdata(rd[g]), .resp_err(er[g]),
            .mem_valid(mv[g]), .mem_raddr(mra[g]), .mem_wen(mw[g]), .mem_waddr(mwa[g]),
            .mem_wdata(mwd[g]), .mem_wmask(mwm[g]), .mem_rdata(mrd[g])
        );
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one request to instance g for a single accept cycle; returns one cycle after accept.
    task automatic issue(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic un);
        checks++;
        if (rr[g] !== 1'b1) begin errors++; $display("FAIL issue_ready dut%0d got=%b exp=1", g, rr[g]); end
        req_wen = w; req_addr = a; req_wdata = d; req_size = s; req_unsigned = un;
        rv[g] = 1'b1;
        tick;
        rv[g] = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 0;
        tick; tick;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({rr[g], vv[g], er[g], mv[g], mw[g]} !== 5'b0 || rd[g] !== 0 || mra[g] !== 0 ||
                mwa[g] !== 0 || mwd[g] !== 0 || mwm[g] !== 0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d rr=%b vv=%b er=%b mv=%b rd=%h mwm=%h exp all zero",
                         g, rr[g], vv[g], er[g], mv[g], rd[g], mwm[g]);
            end
        end
        resetn = 1;
        tick;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (rr[g] !== 1'b1) begin errors++; $display("FAIL reset_idle_ready dut%0d got=%b exp=1", g, rr[g]); end
        end
    endtask

    task automatic test_load_byte(input logic un, input logic [31:0] exp);
        issue(0, 0, 32'h80000003, 0, 2'd0, un);
        checks++;
        if (mv[0] !== 1'b1 || mra[0] !== 32'h80000000 || mw[0] !== 1'b0) begin
            errors++; $display("FAIL lb_access mv=%b raddr=%h wen=%b exp 1/80000000/0", mv[0], mra[0], mw[0]);
        end
        tick;
        checks++;
        if (vv[0] !== 1'b1 || rd[0] !== exp || er[0] !== 1'b0 || mv[0] !== 1'b0) begin
            errors++; $display("FAIL lb_resp un=%b valid=%b rdata=%h err=%b mv=%b exp 1/%h/0/0",
                               un, vv[0], rd[0], er[0], mv[0], exp);
        end
        tick;
        checks++;
        if (rr[0] !== 1'b1 || vv[0] !== 1'b0) begin
            errors++; $display("FAIL lb_idle ready=%b valid=%b exp 1/0", rr[0], vv[0]);
        end
    endtask

    task automatic test_store_half;
        issue(0, 1, 32'h80000002, 32'h00001234, 2'd1, 0);
        checks++;
        if (mv[0] !== 1'b1 || mw[0] !== 1'b1 || mwa[0] !== 32'h80000000 ||
            mwm[0] !== 8'h0C || mwd[0] !== 32'h12340000) begin
            errors++; $display("FAIL sh_access mv=%b wen=%b waddr=%h wmask=%h wdata=%h exp 1/1/80000000/0c/12340000",
                               mv[0], mw[0], mwa[0], mwm[0], mwd[0]);
        end
        tick;
        checks++;
        if (vv[0] !== 1'b1 || rd[0] !== 32'd0 || mv[0] !== 1'b0) begin
            errors++; $display("FAIL sh_resp valid=%b rdata=%h mv=%b exp 1/0/0", vv[0], rd[0], mv[0]);
        end
        tick;
        issue(0, 0, 32'h80000000, 0, 2'd2, 0);
        tick;
        checks++;
        if (vv[0] !== 1'b1 || rd[0] !== 32'h1234AABB) begin
            errors++; $display("FAIL sh_readback valid=%b rdata=%h exp 1/1234aabb", vv[0], rd[0]);
        end
        tick;
    endtask

    task automatic test_latency;
        issue(1, 0, 32'h80000000, 0, 2'd2, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mv[1] !== 1'b0 || vv[1] !== 1'b0) begin
                errors++; $display("FAIL lat_wait cyc=%0d mv=%b valid=%b exp 0/0", i + 1, mv[1], vv[1]);
            end
            tick;
        end
        checks++;
        if (mv[1] !== 1'b1 || vv[1] !== 1'b0) begin
            errors++; $display("FAIL lat_access mv=%b valid=%b exp 1/0", mv[1], vv[1]);
        end
        tick;
        checks++;
        if (mv[1] !== 1'b0 || vv[1] !== 1'b1 || rd[1] !== 32'h8899AABB) begin
            errors++; $display("FAIL lat_resp mv=%b valid=%b rdata=%h exp 0/1/8899aabb", mv[1], vv[1], rd[1]);
        end
        tick;
    endtask

    task automatic test_misalign;
        issue(0, 0, 32'h80000001, 0, 2'd2, 0);
`ifdef LSU_MISALIGN_EXC_EN
        checks++;
        if (vv[0] !== 1'b1 || er[0] !== 1'b1 || rd[0] !== 32'd0 || mv[0] !== 1'b0) begin
            errors++; $display("FAIL mis_err valid=%b err=%b rdata=%h mv=%b exp 1/1/0/0", vv[0], er[0], rd[0], mv[0]);
        end
        tick;
        checks++;
        if (mv[0] !== 1'b0 || rr[0] !== 1'b1) begin
            errors++; $display("FAIL mis_idle mv=%b ready=%b exp 0/1", mv[0], rr[0]);
        end
`else
        checks++;
        if (mv[0] !== 1'b1 || mra[0] !== 32'h80000000) begin
            errors++; $display("FAIL mis_align mv=%b raddr=%h exp 1/80000000", mv[0], mra[0]);
        end
        tick;
        checks++;
        if (vv[0] !== 1'b1 || er[0] !== 1'b0 || rd[0] !== 32'h1234AABB) begin
            errors++; $display("FAIL mis_resp valid=%b err=%b rdata=%h exp 1/0/1234aabb", vv[0], er[0], rd[0]);
        end
        tick;
`endif
    endtask

    task automatic test_backpressure;
        resp_ready = 0;
        issue(0, 0, 32'h80000000, 0, 2'd0, 1);
        tick;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (vv[0] !== 1'b1 || rd[0] !== 32'h000000BB || rr[0] !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc=%0d valid=%b rdata=%h ready=%b exp 1/000000bb/0",
                                   i, vv[0], rd[0], rr[0]);
            end
            tick;
        end
        resp_ready = 1;
        tick;
        checks++;
        if (rr[0] !== 1'b1 || vv[0] !== 1'b0) begin
            errors++; $display("FAIL bp_release ready=%b valid=%b exp 1/0", rr[0], vv[0]);
        end
    endtask

    task automatic test_reset_wait;
        issue(2, 1, 32'h80000004, 32'hDEADBEEF, 2'd2, 0);
        checks++;
        if (mv[2] !== 1'b0) begin errors++; $display("FAIL rw_wait mv=%b exp 0", mv[2]); end
        resetn = 0;
        #1;
        checks++;
        if (mv[2] !== 1'b0 || rr[2] !== 1'b0 || vv[2] !== 1'b0) begin
            errors++; $display("FAIL rw_inreset mv=%b ready=%b valid=%b exp 0/0/0", mv[2], rr[2], vv[2]);
        end
        tick;
        resetn = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mv[2] !== 1'b0 || vv[2] !== 1'b0 || mwm[2] !== 8'd0) begin
                errors++; $display("FAIL rw_nopulse cyc=%0d mv=%b valid=%b wmask=%h exp 0/0/00", i, mv[2], vv[2], mwm[2]);
            end
            tick;
        end
        checks++;
        if (rr[2] !== 1'b1) begin errors++; $display("FAIL rw_idle ready=%b exp 1", rr[2]); end
    endtask

    initial begin
        test_reset;
        test_load_byte(0, 32'hFFFFFF88);
        test_load_byte(1, 32'h00000088);
        test_store_half;
        test_latency;
        test_misalign;
        test_backpressure;
        test_reset_wait;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
